// File: rtl/semaphore_lamp_ctrl_if.sv
// Control and lamp/status bundle for one signal head.
// The junction controller is the master; the lamp sequencer is the slave.
interface semaphore_lamp_ctrl_if;
    logic       en;
    logic       set;
    logic       change;
    logic       lamp_r;
    logic       lamp_y;
    logic       lamp_g;
    logic       green;
    logic       busy;
    logic [2:0] state;

    modport master (
        output en, set, change,
        input  lamp_r, lamp_y, lamp_g, green, busy, state
    );

    modport slave (
        input  en, set, change,
        output lamp_r, lamp_y, lamp_g, green, busy, state
    );
endinterface

// File: rtl/semaphore_lamp_ctrl.sv
// Lamp sequencer for one signal head: OFF/RED/Y2G/GREEN/Y2R with internally timed amber phases,
// a one-deep pending change request and a half-second amber flash in OFF.
module semaphore_lamp_ctrl #(
    parameter int unsigned TICK_DIV = 48_000_000,
    parameter int unsigned T_Y2G    = 2,
    parameter int unsigned T_Y2R    = 3
) (
    input logic                  CLK,
    input logic                  resetn,
    semaphore_lamp_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        StOff   = 3'd0,
        StRed   = 3'd1,
        StY2g   = 3'd2,
        StGreen = 3'd3,
        StY2r   = 3'd4
    } state_e;

    localparam int unsigned PW       = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PcntLast = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PcntHalf = PW'(TICK_DIV / 2 - 1);
    localparam logic [7:0] YLoadG = (T_Y2G[7:0] == 8'd0) ? 8'd1 : T_Y2G[7:0];
    localparam logic [7:0] YLoadR = (T_Y2R[7:0] == 8'd0) ? 8'd1 : T_Y2R[7:0];

    logic [2:0]    state_q, state_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [7:0]    ycnt_q, ycnt_d;
    logic          flash_q, flash_d;
    logic          pend_q, pend_d;
    logic          lamp_r_q, lamp_y_q, lamp_g_q, green_q, busy_q;
    logic          sec_tick, expire, req;

    always_comb begin
        sec_tick = (pcnt_q == PcntLast);
        expire   = sec_tick && (ycnt_q == 8'd1);
        req      = bus.change | pend_q;
        state_d  = state_q;
        pend_d   = pend_q;

        if (!bus.en) begin
            state_d = StOff;
            pend_d  = 1'b0;
        end else begin
            case (state_q)
                StOff:   state_d = bus.set ? StRed : StGreen;
                StRed: begin
                    if (req) begin
                        state_d = StY2g;
                        pend_d  = 1'b0;
                    end
                end
                StGreen: begin
                    if (req) begin
                        state_d = StY2r;
                        pend_d  = 1'b0;
                    end
                end
                StY2g: begin
                    if (bus.change) pend_d = 1'b1;
                    if (expire) state_d = StGreen;
                end
                StY2r: begin
                    if (bus.change) pend_d = 1'b1;
                    if (expire) state_d = StRed;
                end
                default: state_d = StRed;
            endcase
        end

        // Every state starts on a whole second.
        if (state_d != state_q) begin
            pcnt_d = '0;
            ycnt_d = (state_d == StY2g) ? YLoadG : (state_d == StY2r) ? YLoadR : 8'd0;
        end else begin
            pcnt_d = sec_tick ? '0 : pcnt_q + 1'b1;
            ycnt_d = (sec_tick && ycnt_q != 8'd0) ? ycnt_q - 8'd1 : ycnt_q;
        end

        if (state_d == StOff && state_q != StOff) begin
            flash_d = 1'b0;
        end else if (pcnt_q == PcntHalf || sec_tick) begin
            flash_d = ~flash_q;
        end else begin
            flash_d = flash_q;
        end
    end

    // Lamps are decoded from the next state so they line up with the state register.
    always_ff @(posedge CLK or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StOff;
            pcnt_q   <= '0;
            ycnt_q   <= 8'd0;
            flash_q  <= 1'b0;
            pend_q   <= 1'b0;
            lamp_r_q <= 1'b0;
            lamp_y_q <= 1'b0;
            lamp_g_q <= 1'b0;
            green_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            pcnt_q   <= pcnt_d;
            ycnt_q   <= ycnt_d;
            flash_q  <= flash_d;
            pend_q   <= pend_d;
            lamp_r_q <= (state_d == StRed) || (state_d == StY2g);
            lamp_y_q <= (state_d == StY2g) || (state_d == StY2r) ||
                        ((state_d == StOff) && flash_d);
            lamp_g_q <= (state_d == StGreen);
            green_q  <= (state_d == StGreen);
            busy_q   <= (state_d == StY2g) || (state_d == StY2r);
        end
    end

    assign bus.state  = state_q;
    assign bus.lamp_r = lamp_r_q;
    assign bus.lamp_y = lamp_y_q;
    assign bus.lamp_g = lamp_g_q;
    assign bus.green  = green_q;
    assign bus.busy   = busy_q;
endmodule

// File: tb/tb_semaphore_lamp_ctrl.sv
// Directed bench for semaphore_lamp_ctrl with TICK_DIV=10; a second instance uses T_Y2G=0.
module tb_semaphore_lamp_ctrl;
    logic CLK = 1'b0;
    logic resetn = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;
    int   n, bad;

    semaphore_lamp_ctrl_if bus ();
    semaphore_lamp_ctrl_if bus2 ();

    semaphore_lamp_ctrl #(.TICK_DIV(10), .T_Y2G(2), .T_Y2R(3)) dut (
        .CLK    (CLK),
        .resetn (resetn),
        .bus    (bus)
    );

    semaphore_lamp_ctrl #(.TICK_DIV(10), .T_Y2G(0), .T_Y2R(3)) dut2 (
        .CLK    (CLK),
        .resetn (resetn),
        .bus    (bus2)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL timeout: bench did not finish, observed running expected finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    task automatic pulse_change(input bit sel);
        if (sel) bus2.change = 1'b1; else bus.change = 1'b1;
        tick();
        bus.change  = 1'b0;
        bus2.change = 1'b0;
    endtask

    // Count cycles spent in state st; bad counts cycles whose {r,y,g,busy} differ from exp.
    task automatic count_state(input bit sel, input logic [2:0] st, input logic [3:0] exp,
                               output int cnt, output int nbad);
        logic [2:0] s;
        logic [3:0] l;
        cnt  = 0;
        nbad = 0;
        s = sel ? bus2.state : bus.state;
        while (s === st && cnt < 200) begin
            l = sel ? {bus2.lamp_r, bus2.lamp_y, bus2.lamp_g, bus2.busy}
                    : {bus.lamp_r, bus.lamp_y, bus.lamp_g, bus.busy};
            if (l !== exp) nbad++;
            cnt++;
            tick();
            s = sel ? bus2.state : bus.state;
        end
    endtask

    initial begin
        bus.en = 1'b0;  bus.set = 1'b0;  bus.change = 1'b0;
        bus2.en = 1'b0; bus2.set = 1'b0; bus2.change = 1'b0;
        #1;
        check("reset_state", bus.state, 0);
        check("reset_lamps", {bus.lamp_r, bus.lamp_y, bus.lamp_g}, 0);
        check("reset_status", {bus.green, bus.busy}, 0);
        tick(); tick();
        resetn = 1'b1;
        tick();
        check("off_idle_lamps", {bus.lamp_r, bus.lamp_y, bus.lamp_g}, 0);

        // 1: enable to RED, then red+amber for 20 cycles into GREEN
        bus.en = 1'b1; bus.set = 1'b1;
        tick();
        check("t1_red_state", bus.state, 1);
        check("t1_red_lamps", {bus.lamp_r, bus.lamp_y, bus.lamp_g}, 3'b100);
        pulse_change(1'b0);
        count_state(1'b0, 3'd2, 4'b1101, n, bad);
        check("t1_y2g_len", n, 20);
        check("t1_y2g_lamps_bad", bad, 0);
        check("t1_green_state", bus.state, 3);
        check("t1_green_lamps", {bus.lamp_r, bus.lamp_y, bus.lamp_g}, 3'b001);
        check("t1_green_status", {bus.green, bus.busy}, 2'b10);

        // 2: GREEN -> amber for 30 cycles -> RED
        pulse_change(1'b0);
        count_state(1'b0, 3'd4, 4'b0101, n, bad);
        check("t2_y2r_len", n, 30);
        check("t2_y2r_lamps_bad", bad, 0);
        check("t2_red_state", bus.state, 1);

        // 3: two changes during Y2R give one request: 1 cycle of RED then Y2G
        pulse_change(1'b0);
        count_state(1'b0, 3'd2, 4'b1101, n, bad);
        pulse_change(1'b0);
        tick(); tick();
        pulse_change(1'b0);
        tick(); tick(); tick(); tick();
        pulse_change(1'b0);
        count_state(1'b0, 3'd4, 4'b0101, n, bad);
        check("t3_y2r_rest_len", n, 22);
        count_state(1'b0, 3'd1, 4'b1000, n, bad);
        check("t3_red_len", n, 1);
        count_state(1'b0, 3'd2, 4'b1101, n, bad);
        check("t3_y2g_len", n, 20);
        check("t3_green_state", bus.state, 3);
        repeat (50) tick();
        check("t3_green_stays", bus.state, 3);

        // 4: disable into flashing OFF; change ignored; re-enable with set=0
        bus.en = 1'b0;
        tick();
        check("t4_off_state", bus.state, 0);
        check("t4_off_rg", {bus.lamp_r, bus.lamp_g}, 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.lamp_y !== ((i % 10) >= 5)) bad++;
            if (bus.state !== 3'd0) bad++;
            bus.change = (i == 12);
            tick();
        end
        bus.change = 1'b0;
        check("t4_flash_bad", bad, 0);
        bus.en = 1'b1; bus.set = 1'b0;
        tick();
        check("t4_reenable_state", bus.state, 3);
        check("t4_reenable_green", bus.lamp_g, 1);

        // 5: asynchronous reset mid-Y2G
        bus.en = 1'b0;
        tick();
        bus.en = 1'b1; bus.set = 1'b1;
        tick();
        pulse_change(1'b0);
        repeat (5) tick();
        check("t5_in_y2g", bus.state, 2);
        #2 resetn = 1'b0;
        #1;
        check("t5_async_state", bus.state, 0);
        check("t5_async_lamps", {bus.lamp_r, bus.lamp_y, bus.lamp_g, bus.busy}, 0);
        tick();
        resetn = 1'b1;
        tick();
        check("t5_after_reset_state", bus.state, 1);
        check("t5_after_reset_red", bus.lamp_r, 1);

        // 6: T_Y2G=0 instance holds Y2G for one second; illegal state recovers to RED
        bus2.en = 1'b1; bus2.set = 1'b1;
        tick();
        pulse_change(1'b1);
        count_state(1'b1, 3'd2, 4'b1101, n, bad);
        check("t6_y2g_len", n, 10);
        check("t6_green_state", bus2.state, 3);
        force dut2.state_q = 3'd6;
        #1 release dut2.state_q;
        #1;
        check("t6_illegal_seen", bus2.state, 6);
        tick();
        check("t6_illegal_to_red", bus2.state, 1);
        check("t6_illegal_red_lamp", bus2.lamp_r, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
